// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
package mcu_pkg;

    typedef enum logic [3:0] {
        FETCH_S  = 4'd0,
        DECODE_S = 4'd1,
        MEMADR_S = 4'd2,
        MEMRD_S  = 4'd3,
        MEMWB_S  = 4'd4,
        MEMWR_S  = 4'd5,
        EXEC_S   = 4'd6,
        ALUWB_S  = 4'd7,
        BRANCH_S = 4'd8,
        JUMP_S   = 4'd9,
        ADDIEX_S = 4'd10,
        ADDIWB_S = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mcu_output_decode.sv
// Moore output decode: maps the current state to the datapath control vector.
module mcu_output_decode
    import mcu_pkg::*;
(
    input  logic   reset,
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                FETCH_S: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.ir_write  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.pc_write  = 1'b1;
                end
                DECODE_S: ctrl.alu_src_b = SRCB_IMM_SH2;
                MEMADR_S: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                MEMRD_S: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                MEMWB_S: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEMWR_S: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                EXEC_S: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                ALUWB_S: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                BRANCH_S: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                JUMP_S: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                ADDIEX_S: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end
                ADDIWB_S: ctrl.reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and stretches memory states while MemReady is low.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OP_W        = 6,
    parameter bit          ENABLE_JUMP = 1'b1,
    parameter bit          ENABLE_ADDI = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            MemReady,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemToReg,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            IllegalOp,
    output logic [3:0]      State
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   illegal;

    logic is_rtype, is_lw, is_sw, is_beq, is_j, is_addi;
    assign is_rtype = (Op == OP_W'(OP_RTYPE));
    assign is_lw    = (Op == OP_W'(OP_LW));
    assign is_sw    = (Op == OP_W'(OP_SW));
    assign is_beq   = (Op == OP_W'(OP_BEQ));
    assign is_j     = (Op == OP_W'(OP_J)) && ENABLE_JUMP;
    assign is_addi  = (Op == OP_W'(OP_ADDI)) && ENABLE_ADDI;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= FETCH_S;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            FETCH_S: if (MemReady) state_d = DECODE_S;
            DECODE_S: begin
                if (is_lw || is_sw)  state_d = MEMADR_S;
                else if (is_rtype)   state_d = EXEC_S;
                else if (is_beq)     state_d = BRANCH_S;
                else if (is_j)       state_d = JUMP_S;
                else if (is_addi)    state_d = ADDIEX_S;
                else begin
                    state_d = FETCH_S;
                    illegal = 1'b1;
                end
            end
            MEMADR_S: state_d = is_lw ? MEMRD_S : MEMWR_S;
            MEMRD_S:  if (MemReady) state_d = MEMWB_S;
            MEMWB_S:  state_d = FETCH_S;
            MEMWR_S:  if (MemReady) state_d = FETCH_S;
            EXEC_S:   state_d = ALUWB_S;
            ALUWB_S:  state_d = FETCH_S;
            BRANCH_S: state_d = FETCH_S;
            JUMP_S:   state_d = FETCH_S;
            ADDIEX_S: state_d = ADDIWB_S;
            ADDIWB_S: state_d = FETCH_S;
            default:  state_d = FETCH_S;
        endcase
    end

    mcu_output_decode u_decode (
        .reset (reset),
        .state (state_q),
        .ctrl  (ctrl)
    );

    // The PC and IR only load once the fetch read has actually completed.
    assign PCWrite     = ctrl.pc_write & ((state_q != FETCH_S) | MemReady);
    assign IRWrite     = ctrl.ir_write & ((state_q != FETCH_S) | MemReady);
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign IllegalOp   = illegal & ~reset;
    assign State       = reset ? 4'd0 : state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle MIPS main control unit: a Moore state machine replacing the single-cycle opcode decoder. Sequences each instruction through fetch, decode, execute, memory and write-back steps, and drives all datapath enables and multiplexer selects. Sits between the instruction register's opcode field and the shared multicycle datapath (PC, IR, register file, ALU, unified memory). Stretches memory states on a wait handshake and optionally supports `j` and `addi`.

## Interface
- OP_W, 6: opcode width.
- ENABLE_JUMP, 1: 1 = decode `j` (opcode 6'h02); 0 = treat it as illegal.
- ENABLE_ADDI, 1: 1 = decode `addi` (opcode 6'h08); 0 = treat it as illegal.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH_S.
- Op  in  OP_W  opcode from the IR.
- MemReady  in  1  memory handshake; the access completes in the cycle it is 1.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct field.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- IllegalOp  out  1  one-cycle pulse in DECODE_S when the opcode is unsupported.
- State  out  4  current state, for debug.

## Operation
- Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02 (gated), addi 0x08 (gated).
- Outputs are a function of state only. Exceptions: PCWrite and IRWrite in FETCH_S are ANDed with MemReady. While reset is high, every output is 0 and State is 0.
- Any control not listed below is 0 in that state.

States and their asserted controls:
- FETCH_S (0): MemRead, IRWrite, ALUSrcB=01, PCWrite. Goes to DECODE_S when MemReady=1, otherwise holds.
- DECODE_S (1): ALUSrcB=11. Branches on Op:
  - lw/sw → MEMADR_S
  - R-type → EXEC_S
  - beq → BRANCH_S
  - j → JUMP_S
  - addi → ADDIEX_S
  - anything else → FETCH_S, with IllegalOp=1
- MEMADR_S (2): ALUSrcA, ALUSrcB=10. Goes to MEMRD_S for lw, MEMWR_S for sw.
- MEMRD_S (3): MemRead, IorD. Goes to MEMWB_S when MemReady=1, otherwise holds.
- MEMWB_S (4): RegWrite, MemToReg. Goes to FETCH_S.
- MEMWR_S (5): MemWrite, IorD. Goes to FETCH_S when MemReady=1, otherwise holds.
- EXEC_S (6): ALUSrcA, ALUOp=10. Goes to ALUWB_S.
- ALUWB_S (7): RegDst, RegWrite. Goes to FETCH_S.
- BRANCH_S (8): ALUSrcA, ALUOp=01, PCWriteCond, PCSource=01. Goes to FETCH_S.
- JUMP_S (9): PCWrite, PCSource=10. Goes to FETCH_S.
- ADDIEX_S (10): ALUSrcA, ALUSrcB=10. Goes to ADDIWB_S.
- ADDIWB_S (11): RegWrite. Goes to FETCH_S.
- Unused encodings 12–15 go to FETCH_S on the next edge, with all outputs 0.

## Timing
- Latency with MemReady held at 1:
  - beq, j: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
- Each cycle MemReady=0 adds one cycle, and only in FETCH_S, MEMRD_S or MEMWR_S.
- MemRead, MemWrite and IorD hold steady throughout a stall.
- Op is sampled only in DECODE_S and MEMADR_S; the IR holds it stable there.
- Reset asserted mid-instruction: state and outputs clear asynchronously. The first fetch begins on the first rising edge after reset deasserts.
- MemReady=0 in a non-memory state has no effect.

## Structure
- Package mcu_pkg holds:
  - the state enum and encodings 0–11
  - opcode localparams
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module mcu_output_decode: purely combinational, state → control vector, including the reset gating. The top level keeps the state register, next-state logic and the MemReady qualification.

## Test plan
- Reset, then R-type (Op=0x00) with MemReady=1 → states 0,1,6,7,0. RegDst=RegWrite=1 only in state 7. ALUOp=10 in state 6.
- lw (0x23) with MemReady=0 for 2 cycles in MEMRD_S → states 0,1,2,3,3,3,4,0. MemRead=IorD=1 throughout state 3. MemToReg=1 in state 4.
- sw (0x2B) then beq (0x04) → 0,1,2,5,0 then 0,1,8,0. PCWriteCond=1 and PCSource=01 in state 8.
- j (0x02) and addi (0x08) with ENABLE_*=1 → 0,1,9,0 and 0,1,10,11,0. Same opcodes with ENABLE_*=0 → IllegalOp=1 in state 1, then state 0.
- Reset asserted in MEMRD_S mid-stall → State=0 and all outputs 0 immediately. After release, a fetch follows with PCWrite=IRWrite=MemReady.
- FETCH_S with MemReady=0 for 3 cycles → PCWrite=IRWrite=0 and state held at 0. The transition to state 1 occurs on the first edge with MemReady=1.
